// File: rtl/sensor_uart_formatter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sensor_uart_formatter
//
// Purpose: turns one temperature sample and one light sample (8-bit unsigned
// each) into a fixed ASCII line such as "T=025 L=200\r\n". The line is
// streamed one byte at a time into a uart_tx stage. Only one line is in
// flight at a time. A sample that arrives while a line is in flight is
// dropped and flagged.
//
// Parameters:
//   CRLF      : 1 ends the line with 0x0D 0x0A (13 bytes), 0 ends it with 0x0A (12 bytes)
//   TEMP_TAG  : tag byte for the temperature field
//   LIGHT_TAG : tag byte for the light field
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   temp_in      in   [7:0] temperature value
//   light_in     in   [7:0] light value
//   sample_valid in   one-cycle strobe qualifying temp_in/light_in
//   tx_busy      in   busy flag from uart_tx
//   data_out     out  [7:0] byte to uart_tx data_in
//   tx_start     out  one-cycle start pulse to uart_tx
//   busy         out  high from sample acceptance until the last byte completes
//   frame_done   out  one-cycle pulse as the last byte completes
//   dropped      out  one-cycle pulse, the cycle after a sample is refused
//   o_dbg_state  out  [2:0] current FSM state (0 IDLE, 1 CONV, 2 LOAD,
//                     3 WAIT_ACK, 4 WAIT_DONE)
//
// Handshake with uart_tx: a byte is offered only when tx_busy is low. The
// byte sits on data_out and tx_start pulses for exactly one cycle. The FSM
// then waits for tx_busy to rise, which means uart_tx accepted the byte.
// It then waits for tx_busy to fall, which means the byte finished. data_out
// holds steady from the start pulse until the next byte is loaded.
// ---------------------------------------------------------------------------
module sensor_uart_formatter #(
  parameter int unsigned CRLF      = 1,
  parameter logic [7:0]  TEMP_TAG  = 8'h54,
  parameter logic [7:0]  LIGHT_TAG = 8'h4C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] temp_in,
  input  logic [7:0] light_in,
  input  logic       sample_valid,
  input  logic       tx_busy,
  output logic [7:0] data_out,
  output logic       tx_start,
  output logic       busy,
  output logic       frame_done,
  output logic       dropped,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CONV      = 3'd1,
    S_LOAD      = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  localparam logic [3:0] LAST_IDX = (CRLF != 0) ? 4'd12 : 4'd11;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_t_bin;
  logic [7:0]  r_l_bin;
  logic [11:0] r_t_bcd;
  logic [11:0] r_l_bcd;
  logic [2:0]  r_cnt;
  logic [3:0]  r_idx;
  logic [7:0]  r_data_out;
  logic        r_tx_start;
  logic        r_dropped;

  logic        w_latch;
  logic        w_step;
  logic        w_start;
  logic        w_idx_inc;
  logic        w_frame_done;
  logic [11:0] w_t_adj;
  logic [11:0] w_l_adj;
  logic [7:0]  w_byte;

  // Double-dabble correction: any BCD digit of 5 or more gets +3 before
  // the next left shift, so it carries correctly into the next decade.
  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign w_t_adj = add3(r_t_bcd);
  assign w_l_adj = add3(r_l_bcd);

  // Byte mux. Digits are always below 10, so 0x30 + digit is the same as
  // putting the digit under a 0x3 upper nibble.
  always_comb begin
    w_byte = 8'h0A;
    case (r_idx)
      4'd0:    w_byte = TEMP_TAG;
      4'd1:    w_byte = 8'h3D;
      4'd2:    w_byte = {4'h3, r_t_bcd[11:8]};
      4'd3:    w_byte = {4'h3, r_t_bcd[7:4]};
      4'd4:    w_byte = {4'h3, r_t_bcd[3:0]};
      4'd5:    w_byte = 8'h20;
      4'd6:    w_byte = LIGHT_TAG;
      4'd7:    w_byte = 8'h3D;
      4'd8:    w_byte = {4'h3, r_l_bcd[11:8]};
      4'd9:    w_byte = {4'h3, r_l_bcd[7:4]};
      4'd10:   w_byte = {4'h3, r_l_bcd[3:0]};
      4'd11:   w_byte = (CRLF != 0) ? 8'h0D : 8'h0A;
      default: w_byte = 8'h0A;
    endcase
  end

  // Next-state and control strobes.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_step       = 1'b0;
    w_start      = 1'b0;
    w_idx_inc    = 1'b0;
    w_frame_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (sample_valid) begin
          w_latch      = 1'b1;
          w_state_next = S_CONV;
        end
      end
      S_CONV: begin
        w_step = 1'b1;
        if (r_cnt == 3'd7) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        if (!tx_busy) begin
          w_start      = 1'b1;
          w_state_next = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (tx_busy) w_state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (r_idx == LAST_IDX) begin
            w_frame_done = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_idx_inc    = 1'b1;
            w_state_next = S_LOAD;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_t_bin    <= '0;
      r_l_bin    <= '0;
      r_t_bcd    <= '0;
      r_l_bcd    <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_data_out <= '0;
      r_tx_start <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tx_start <= w_start;
      // Any strobe outside IDLE is refused. This includes the frame_done
      // cycle, because the FSM is still in WAIT_DONE then.
      r_dropped  <= sample_valid && (r_state != S_IDLE);
      if (w_latch) begin
        r_t_bin <= temp_in;
        r_l_bin <= light_in;
        r_t_bcd <= '0;
        r_l_bcd <= '0;
        r_cnt   <= '0;
      end
      if (w_step) begin
        // The binary value is rotated, not shifted. After eight steps the
        // latched sample is back in place, unchanged.
        r_t_bcd <= {w_t_adj[10:0], r_t_bin[7]};
        r_l_bcd <= {w_l_adj[10:0], r_l_bin[7]};
        r_t_bin <= {r_t_bin[6:0], r_t_bin[7]};
        r_l_bin <= {r_l_bin[6:0], r_l_bin[7]};
        r_cnt   <= r_cnt + 3'd1;
        r_idx   <= '0;
      end
      if (r_state == S_LOAD) r_data_out <= w_byte;
      if (w_idx_inc) r_idx <= r_idx + 4'd1;
    end
  end

  assign data_out    = r_data_out;
  assign tx_start    = r_tx_start;
  assign dropped     = r_dropped;
  assign frame_done  = w_frame_done;
  // busy drops on the frame_done cycle itself.
  assign busy        = (r_state != S_IDLE) && !w_frame_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sensor_uart_formatter.sv
`timescale 1ns/1ps
module tb_sensor_uart_formatter;

  localparam int BYTE_CYC = 6;
  localparam int TMO      = 3000;

  // ---------------- clock / reset / shared stimulus ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] temp_in;
  logic [7:0] light_in;
  logic       sample_valid;
  logic       hold_busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0: CRLF=1, dut1: CRLF=0, both fed the same samples.
  logic       tx_busy0, tx_busy1;
  logic [7:0] data_out0, data_out1;
  logic       tx_start0, tx_start1, busy0, busy1;
  logic       frame_done0, frame_done1, dropped0, dropped1;
  logic [2:0] dbg0, dbg1;

  sensor_uart_formatter #(.CRLF(1)) dut0 (
    .clk(clk), .rst(rst), .temp_in(temp_in), .light_in(light_in),
    .sample_valid(sample_valid), .tx_busy(tx_busy0), .data_out(data_out0),
    .tx_start(tx_start0), .busy(busy0), .frame_done(frame_done0),
    .dropped(dropped0), .o_dbg_state(dbg0));

  sensor_uart_formatter #(.CRLF(0)) dut1 (
    .clk(clk), .rst(rst), .temp_in(temp_in), .light_in(light_in),
    .sample_valid(sample_valid), .tx_busy(tx_busy1), .data_out(data_out1),
    .tx_start(tx_start1), .busy(busy1), .frame_done(frame_done1),
    .dropped(dropped1), .o_dbg_state(dbg1));

  // uart_tx models: busy for BYTE_CYC cycles after each start pulse,
  // and forced high while hold_busy is set.
  int cnt0 = 0, cnt1 = 0;
  always @(posedge clk) begin
    if (tx_start0) cnt0 <= BYTE_CYC; else if (cnt0 != 0) cnt0 <= cnt0 - 1;
    if (tx_start1) cnt1 <= BYTE_CYC; else if (cnt1 != 0) cnt1 <= cnt1 - 1;
  end
  assign tx_busy0 = hold_busy || (cnt0 != 0);
  assign tx_busy1 = hold_busy || (cnt1 != 0);

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int checks = 0, errors = 0;
  int st_cnt0 = 0, st_cnt1 = 0, fd_cnt0 = 0, fd_cnt1 = 0, dr_cnt0 = 0, dr_cnt1 = 0;
  int exp_fd0 = 0, exp_fd1 = 0, exp_dr0 = 0, exp_dr1 = 0;
  int t_sv = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles (t=%0t)", name, TMO, $time);
  endtask

  function automatic logic [7:0] dig(input logic [7:0] d);
    return 8'h30 + d;
  endfunction

  function automatic void push_line(input int which, input logic [7:0] t, input logic [7:0] l);
    logic [7:0] b[$];
    b = '{8'h54, 8'h3D, dig(t / 8'd100), dig((t / 8'd10) % 8'd10), dig(t % 8'd10), 8'h20,
          8'h4C, 8'h3D, dig(l / 8'd100), dig((l / 8'd10) % 8'd10), dig(l % 8'd10)};
    if (which == 0) begin
      foreach (b[i]) exp_q0.push_back(b[i]);
      exp_q0.push_back(8'h0D);
      exp_q0.push_back(8'h0A);
    end else begin
      foreach (b[i]) exp_q1.push_back(b[i]);
      exp_q1.push_back(8'h0A);
    end
  endfunction

  // Monitor: pop and compare on every start pulse, and track strobes.
  logic prev_st0 = 1'b0, prev_st1 = 1'b0;
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_start0) begin
          st_cnt0++;
          check("start0_while_tx_busy", 32'(tx_busy0), 32'd0);
          check("start0_consecutive", 32'(prev_st0), 32'd0);
          if (exp_q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL byte0: got %02h, no byte expected", data_out0);
          end else begin
            e = exp_q0.pop_front();
            check("byte0", 32'(data_out0), 32'(e));
          end
        end
        if (tx_start1) begin
          st_cnt1++;
          check("start1_while_tx_busy", 32'(tx_busy1), 32'd0);
          check("start1_consecutive", 32'(prev_st1), 32'd0);
          if (exp_q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL byte1: got %02h, no byte expected", data_out1);
          end else begin
            e = exp_q1.pop_front();
            check("byte1", 32'(data_out1), 32'(e));
          end
        end
        if (frame_done0) fd_cnt0++;
        if (frame_done1) fd_cnt1++;
        if (dropped0) dr_cnt0++;
        if (dropped1) dr_cnt1++;
      end
      prev_st0 = tx_start0;
      prev_st1 = tx_start1;
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_sample(input logic [7:0] t, input logic [7:0] l, input bit acc0, input bit acc1);
    temp_in = t; light_in = l; sample_valid = 1'b1; t_sv = cyc;
    if (acc0) begin push_line(0, t, l); exp_fd0++; end else exp_dr0++;
    if (acc1) begin push_line(1, t, l); exp_fd1++; end else exp_dr1++;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (!busy0 && !busy1 && exp_q0.size() == 0 && exp_q1.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) timeout_fail(name);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_start0(input string name, output int lat);
    bit ok = 1'b0;
    lat = -1;
    for (int i = 0; i < TMO; i++) begin
      if (tx_start0) begin ok = 1'b1; lat = cyc - t_sv; break; end
      @(negedge clk);
    end
    if (!ok) timeout_fail(name);
  endtask

  task automatic wait_starts0(input string name, input int n);
    bit ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (st_cnt0 >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) timeout_fail(name);
  endtask

  task automatic wait_fd0(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (frame_done0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) timeout_fail(name);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data0"}, 32'(data_out0), 32'd0);
    check({tag, "_start0"}, 32'(tx_start0), 32'd0);
    check({tag, "_busy0"}, 32'(busy0), 32'd0);
    check({tag, "_fd0"}, 32'(frame_done0), 32'd0);
    check({tag, "_drop0"}, 32'(dropped0), 32'd0);
    check({tag, "_state0"}, 32'(dbg0), 32'd0);
    check({tag, "_data1"}, 32'(data_out1), 32'd0);
    check({tag, "_start1"}, 32'(tx_start1), 32'd0);
    check({tag, "_busy1"}, 32'(busy1), 32'd0);
    check({tag, "_fd1"}, 32'(frame_done1), 32'd0);
    check({tag, "_drop1"}, 32'(dropped1), 32'd0);
    check({tag, "_state1"}, 32'(dbg1), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int base0, base1;
    rst = 1'b1; sample_valid = 1'b0; hold_busy = 1'b0; temp_in = '0; light_in = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Line 1: temp=25, light=200, plus first-start latency.
    send_sample(8'd25, 8'd200, 1'b1, 1'b1);
    wait_start0("lat_wait", lat);
    check("first_start_latency", 32'(lat), 32'd10);
    wait_idle("line_25_200");
    check("busy0_after_line", 32'(busy0), 32'd0);
    check("fd0_after_line", 32'(fd_cnt0), 32'd1);

    // Line 2: temp=0, light=255 (leading zeros, max value).
    send_sample(8'd0, 8'd255, 1'b1, 1'b1);
    wait_idle("line_0_255");

    // tx_busy held high when the first byte is ready.
    hold_busy = 1'b1;
    base0 = st_cnt0;
    send_sample(8'd123, 8'd45, 1'b1, 1'b1);
    repeat (59) @(negedge clk);
    check("no_start_while_held", 32'(st_cnt0 - base0), 32'd0);
    hold_busy = 1'b0;
    wait_start0("hold_release", lat);
    check("held_first_byte", 32'(data_out0), 32'h54);
    @(negedge clk);
    check("held_start_single", 32'(tx_start0), 32'd0);
    wait_idle("line_hold");

    // Sample during byte 4 is dropped; the line keeps its original values.
    base0 = st_cnt0;
    send_sample(8'd25, 8'd200, 1'b1, 1'b1);
    wait_starts0("byte4_wait", base0 + 5);
    base0 = dr_cnt0; base1 = dr_cnt1;
    send_sample(8'd99, 8'd7, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("drop0_pulse", 32'(dr_cnt0 - base0), 32'd1);
    check("drop1_pulse", 32'(dr_cnt1 - base1), 32'd1);
    wait_idle("line_after_drop");
    send_sample(8'd99, 8'd7, 1'b1, 1'b1);

    // Sample on dut0's frame_done cycle: dut0 drops it, dut1 (already idle) takes it.
    wait_fd0("fd_wait_a");
    base0 = dr_cnt0;
    send_sample(8'd11, 8'd22, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("drop_on_frame_done", 32'(dr_cnt0 - base0), 32'd1);
    wait_idle("line_fd_drop");

    // Back-to-back: sample on the cycle after frame_done is accepted.
    send_sample(8'd200, 8'd100, 1'b1, 1'b1);
    wait_fd0("fd_wait_b");
    @(negedge clk);
    base0 = dr_cnt0;
    send_sample(8'd201, 8'd101, 1'b1, 1'b1);
    check("b2b_busy_rises", 32'(busy0), 32'd1);
    repeat (2) @(negedge clk);
    check("b2b_no_drop", 32'(dr_cnt0 - base0), 32'd0);
    wait_idle("line_b2b");

    // Reset in WAIT_DONE of byte 7 abandons the line.
    base0 = st_cnt0;
    send_sample(8'd250, 8'd3, 1'b1, 1'b1);
    wait_starts0("byte7_wait", base0 + 8);
    repeat (3) @(negedge clk);
    check("pre_reset_wait_done", 32'(dbg0), 32'd4);
    rst = 1'b1;
    exp_q0.delete(); exp_q1.delete();
    exp_fd0--; exp_fd1--;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    send_sample(8'd77, 8'd188, 1'b1, 1'b1);
    wait_idle("line_after_reset");

    check("q0_empty", 32'(exp_q0.size()), 32'd0);
    check("q1_empty", 32'(exp_q1.size()), 32'd0);
    check("fd0_total", 32'(fd_cnt0), 32'(exp_fd0));
    check("fd1_total", 32'(fd_cnt1), 32'(exp_fd1));
    check("drop0_total", 32'(dr_cnt0), 32'(exp_dr0));
    check("drop1_total", 32'(dr_cnt1), 32'(exp_dr1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
